data_mem_channels: RTL and testbench
====================================

Name: data_mem_channels

Overview:
Multi-channel global data memory that sits directly downstream of the memory controller's channel interface. Each channel independently accepts one read or write request. It waits a fixed latency, then raises ready and holds it until the requester drops valid. It is backed by one shared word array with per-channel read ports. It serves as the synthesizable data memory for FPGA builds and as the standard memory for controller-level benches.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDRESS_WIDTH, 16, request address width
NUM_CHANNELS, 2, number of independent request channels
MEM_ADDR_BITS, 10, array depth is 2**MEM_ADDR_BITS words; must be <= ADDRESS_WIDTH
READ_LATENCY, 2, cycles from request acceptance to ready; must be >= 1, elaboration $fatal otherwise
WRITE_ENABLE, 1, 0 gives read-only memory

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous active-low reset (asserted at 0)
mem_read_valid  input  [NUM_CHANNELS]  per-channel read request
mem_read_address  input  ADDRESS_WIDTH x NUM_CHANNELS  read address
mem_read_ready  output  [NUM_CHANNELS]  read data valid / request complete
mem_read_data  output  DATA_WIDTH x NUM_CHANNELS  read data
mem_write_valid  input  [NUM_CHANNELS]  per-channel write request
mem_write_address  input  ADDRESS_WIDTH x NUM_CHANNELS  write address
mem_write_data  input  DATA_WIDTH x NUM_CHANNELS  write data
mem_write_ready  output  [NUM_CHANNELS]  write committed
init_we  input  1  preload write strobe for bench/boot loader
init_address  input  ADDRESS_WIDTH  preload address
init_data  input  DATA_WIDTH  preload data

Behaviour:
- Reset (reset=0, asynchronous):
  - all channels go to CH_IDLE; mem_read_ready=0, mem_write_ready=0, mem_read_data=0.
  - latency counters are cleared; in-flight writes are discarded (never committed).
  - array contents are NOT reset.
- Indexing: array index = address[MEM_ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap.
- Per-channel FSM:
  - CH_IDLE: on an edge with mem_read_valid[i]=1, latch the address and kind=READ. Else, if WRITE_ENABLE and mem_write_valid[i]=1, latch address, data and kind=WRITE. Load counter=READ_LATENCY-1 and go to CH_BUSY. Read has priority if both are valid.
  - CH_BUSY: decrement the counter each edge. At the edge where the counter is 0:
    - READ: mem_read_data[i] <= array[idx]; mem_read_ready[i] <= 1.
    - WRITE: array[idx] <= data; mem_write_ready[i] <= 1.
    - Then go to CH_RESPOND.
  - CH_RESPOND: hold ready and data. At an edge where the valid of the latched kind is 0: ready <= 0, go to CH_IDLE. mem_read_data keeps its last value.
- Latency: ready is first visible READ_LATENCY cycles after the accept edge. Ready stays high for at least 1 cycle, and typically 2 with the controller, which drops valid on the edge it samples ready.
- Input stability: changes to the request address/data after acceptance are ignored.
- Read-during-write, same edge, same index: the read returns old data.
- Multiple channel writes to the same index on the same edge: the highest channel index wins.
- Init port: init_we writes the array on any edge, independent of the FSMs. A channel write to the same index on the same edge overrides it.
- WRITE_ENABLE=0: write valids are ignored and mem_write_ready is tied 0.

Decomposition:
- mem_pkg holds the channel state enum (CH_IDLE, CH_BUSY, CH_RESPOND), the request-kind enum (REQ_READ, REQ_WRITE), and the localparam LAT_W=$clog2(READ_LATENCY+1).
- Sub-module mem_channel_fsm, one instance per channel, owns the state, counter, latched request and ready outputs. It emits a commit-strobe/index/data write request and a read-capture strobe.
- The top level owns the array, write-priority resolution, init port and read-data registers.

Test Plan:
- Reset: hold reset=0 with valids high -> all ready=0 and read_data=0. After release, no ready until a request is accepted.
- Preload read: init addr 5=0xDEADBEEF, ch0 read addr 5, READ_LATENCY=2 -> ready rises exactly 2 cycles after the accept edge with data 0xDEADBEEF. Drop valid -> ready falls on the next edge.
- Write then read: ch0 writes 0x0010=0x00001234 and gets ready. Then ch1 reads 0x0010 -> 0x00001234.
- Write collision: ch0 writes addr 7=0xA and ch1 writes addr 7=0xB in the same cycle -> both get ready; a subsequent read of addr 7 returns 0xB.
- Wrap: write 0x0405=0x55 with MEM_ADDR_BITS=10 -> a read of 0x0005 returns 0x55.
- Reset mid-op: addr 9 holds 0x1. Ch0 writes addr 9=0x2; assert reset during CH_BUSY -> ready never rises; after release, reading addr 9 returns 0x1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and width helpers for the multi-channel data memory.
// Channel FSM states, request kinds and latency-counter sizing.
package mem_pkg;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_BUSY,
      CH_RESPOND
   } ch_state_e;

   typedef enum logic {
      REQ_READ,
      REQ_WRITE
   } req_kind_e;

   localparam int DEFAULT_READ_LATENCY = 2;
   localparam int LAT_W = $clog2(DEFAULT_READ_LATENCY + 1);

   // Counter width for an arbitrary latency (modules size from their own parameter).
   function automatic int lat_width(input int latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One request channel: accepts a read or write, counts out the latency, then
// holds ready until the requester drops the valid of the accepted kind.
module mem_channel_fsm
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADDR_BITS = 10,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_read_valid,
   input  logic [MEM_ADDR_BITS-1:0] i_read_idx,
   input  logic                     i_write_valid,
   input  logic [MEM_ADDR_BITS-1:0] i_write_idx,
   input  logic [DATA_WIDTH-1:0]    i_write_data,
   output logic                     o_read_ready,
   output logic                     o_write_ready,
   output logic                     o_commit_we,
   output logic                     o_read_capture,
   output logic [MEM_ADDR_BITS-1:0] o_idx,
   output logic [DATA_WIDTH-1:0]    o_commit_data
);

   localparam int CNT_W = lat_width(READ_LATENCY);

   ch_state_e                r_state, w_state_d;
   req_kind_e                r_kind, w_kind_d;
   logic [CNT_W-1:0]         r_cnt, w_cnt_d;
   logic [MEM_ADDR_BITS-1:0] r_idx, w_idx_d;
   logic [DATA_WIDTH-1:0]    r_data, w_data_d;
   logic                     w_kind_valid;
   logic                     w_fire;

   assign w_kind_valid = (r_kind == REQ_READ) ? i_read_valid : i_write_valid;
   assign w_fire       = (r_state == CH_BUSY) && (r_cnt == '0);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_d = r_state;
      w_kind_d  = r_kind;
      w_cnt_d   = r_cnt;
      w_idx_d   = r_idx;
      w_data_d  = r_data;
      case (r_state)
         CH_IDLE: begin
            if (i_read_valid) begin
               w_kind_d  = REQ_READ;
               w_idx_d   = i_read_idx;
               w_cnt_d   = CNT_W'(READ_LATENCY - 1);
               w_state_d = CH_BUSY;
            end else if ((WRITE_ENABLE != 0) && i_write_valid) begin
               w_kind_d  = REQ_WRITE;
               w_idx_d   = i_write_idx;
               w_data_d  = i_write_data;
               w_cnt_d   = CNT_W'(READ_LATENCY - 1);
               w_state_d = CH_BUSY;
            end
         end
         CH_BUSY: begin
            if (r_cnt == '0) w_state_d = CH_RESPOND;
            else             w_cnt_d   = r_cnt - CNT_W'(1);
         end
         CH_RESPOND: begin
            if (!w_kind_valid) w_state_d = CH_IDLE;
         end
         default: w_state_d = CH_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CH_IDLE;
         r_kind  <= REQ_READ;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_d;
         r_kind  <= w_kind_d;
         r_cnt   <= w_cnt_d;
         r_idx   <= w_idx_d;
         r_data  <= w_data_d;
      end
   end

   // Strobes are gated by state, so a reset while busy drops the pending write.
   assign o_commit_we    = w_fire && (r_kind == REQ_WRITE) && (WRITE_ENABLE != 0);
   assign o_read_capture = w_fire && (r_kind == REQ_READ);
   assign o_idx          = r_idx;
   assign o_commit_data  = r_data;
   assign o_read_ready   = (r_state == CH_RESPOND) && (r_kind == REQ_READ);
   assign o_write_ready  = (WRITE_ENABLE != 0) && (r_state == CH_RESPOND) && (r_kind == REQ_WRITE);

endmodule

// File: rtl/data_mem_channels.sv
// Multi-channel data memory: one shared word array, per-channel request FSMs,
// preload port, and registered per-channel read data.
module data_mem_channels
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 16,
   parameter int NUM_CHANNELS  = 2,
   parameter int MEM_ADDR_BITS = 10,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_CHANNELS-1:0]                    mem_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]                    mem_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_read_data,
   input  logic [NUM_CHANNELS-1:0]                    mem_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_write_data,
   output logic [NUM_CHANNELS-1:0]                    mem_write_ready,
   input  logic                                       init_we,
   input  logic [ADDRESS_WIDTH-1:0]                   init_address,
   input  logic [DATA_WIDTH-1:0]                      init_data
);

   localparam int DEPTH = 2 ** MEM_ADDR_BITS;

   if (READ_LATENCY < 1) begin : g_bad_latency
      $fatal(1, "data_mem_channels: READ_LATENCY must be >= 1");
   end
   if (MEM_ADDR_BITS > ADDRESS_WIDTH) begin : g_bad_addr
      $fatal(1, "data_mem_channels: MEM_ADDR_BITS must be <= ADDRESS_WIDTH");
   end

   logic [DATA_WIDTH-1:0]                      r_mem [DEPTH];
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    r_read_data;
   logic [NUM_CHANNELS-1:0]                    w_commit_we;
   logic [NUM_CHANNELS-1:0]                    w_read_capture;
   logic [NUM_CHANNELS-1:0][MEM_ADDR_BITS-1:0] w_idx;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    w_commit_data;
   logic                                       w_unused;

   // Upper address bits are deliberately ignored so addresses wrap.
   assign w_unused = ^{mem_read_address, mem_write_address, init_address};

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      mem_channel_fsm #(
         .DATA_WIDTH   (DATA_WIDTH),
         .MEM_ADDR_BITS(MEM_ADDR_BITS),
         .READ_LATENCY (READ_LATENCY),
         .WRITE_ENABLE (WRITE_ENABLE)
      ) u_fsm (
         .clk           (clk),
         .rst_n         (reset),
         .i_read_valid  (mem_read_valid[g]),
         .i_read_idx    (mem_read_address[g][MEM_ADDR_BITS-1:0]),
         .i_write_valid (mem_write_valid[g]),
         .i_write_idx   (mem_write_address[g][MEM_ADDR_BITS-1:0]),
         .i_write_data  (mem_write_data[g]),
         .o_read_ready  (mem_read_ready[g]),
         .o_write_ready (mem_write_ready[g]),
         .o_commit_we   (w_commit_we[g]),
         .o_read_capture(w_read_capture[g]),
         .o_idx         (w_idx[g]),
         .o_commit_data (w_commit_data[g])
      );
   end

   // NOTE: the array has no reset; contents survive reset and map onto block RAM.
   // Later assignments win, giving init < channel 0 < ... < highest channel.
   always_ff @(posedge clk) begin
      if (init_we) r_mem[init_address[MEM_ADDR_BITS-1:0]] <= init_data;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (w_commit_we[i]) r_mem[w_idx[i]] <= w_commit_data[i];
      end
   end

   // Reads sample the array before this edge's writes land, returning old data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_read_data <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_read_capture[i]) r_read_data[i] <= r_mem[w_idx[i]];
         end
      end
   end

   assign mem_read_data = r_read_data;

endmodule

// File: tb/tb_data_mem_channels.sv
// Directed bench for data_mem_channels (default parameters: 2 channels,
// 10 index bits, latency 2, writes enabled).
module tb_data_mem_channels;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        rv, rr, wv, wr;
   logic [1:0][15:0]  ra, wa;
   logic [1:0][31:0]  rd, wd;
   logic              init_we;
   logic [15:0]       init_address;
   logic [31:0]       init_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_channels dut (
      .clk              (clk),
      .reset            (reset),
      .mem_read_valid   (rv),
      .mem_read_address (ra),
      .mem_read_ready   (rr),
      .mem_read_data    (rd),
      .mem_write_valid  (wv),
      .mem_write_address(wa),
      .mem_write_data   (wd),
      .mem_write_ready  (wr),
      .init_we          (init_we),
      .init_address     (init_address),
      .init_data        (init_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      init_we = 1'b1; init_address = a; init_data = d;
      step();
      init_we = 1'b0;
   endtask

   task automatic chan_write(input int ch, input logic [15:0] a, input logic [31:0] d, output bit ok);
      wa[ch] = a; wd[ch] = d; wv[ch] = 1'b1; ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         step();
         ok = wr[ch];
      end
      wv[ch] = 1'b0;
      step();
   endtask

   task automatic chan_read(input int ch, input logic [15:0] a, output logic [31:0] got, output bit ok);
      ra[ch] = a; rv[ch] = 1'b1; ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         step();
         ok = rr[ch];
      end
      got = rd[ch];
      rv[ch] = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; rv = 2'b11; wv = 2'b11;
      step(); step();
      checks++; if (rr !== 2'b00) begin errors++; $display("FAIL reset_read_ready got %b want 00", rr); end
      checks++; if (wr !== 2'b00) begin errors++; $display("FAIL reset_write_ready got %b want 00", wr); end
      checks++; if (rd !== 64'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", rd); end
      rv = 2'b00; wv = 2'b00; reset = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if ({rr, wr} !== 4'b0000) begin errors++; $display("FAIL idle_after_reset cycle %0d got rr=%b wr=%b want 00 00", n, rr, wr); end
      end
   endtask

   task automatic test_preload_read();
      preload(16'd5, 32'hDEADBEEF);
      ra[0] = 16'd5; rv[0] = 1'b1;
      step();
      checks++; if (rr[0] !== 1'b0) begin errors++; $display("FAIL lat_cycle1 got %b want 0", rr[0]); end
      step();
      checks++; if (rr[0] !== 1'b0) begin errors++; $display("FAIL lat_cycle2 got %b want 0", rr[0]); end
      step();
      checks++; if (rr[0] !== 1'b1) begin errors++; $display("FAIL lat_ready got %b want 1", rr[0]); end
      checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL preload_data got %h want deadbeef", rd[0]); end
      step();
      checks++; if (rr[0] !== 1'b1) begin errors++; $display("FAIL ready_hold got %b want 1", rr[0]); end
      rv[0] = 1'b0;
      step();
      checks++; if (rr[0] !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", rr[0]); end
      checks++; if (rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL data_kept got %h want deadbeef", rd[0]); end
   endtask

   task automatic test_write_then_read();
      bit ok;
      logic [31:0] got;
      chan_write(0, 16'h0010, 32'h00001234, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wr_ready got 0 want 1 (timeout)"); end
      chan_read(1, 16'h0010, got, ok);
      checks++; if (!ok || got !== 32'h00001234) begin errors++; $display("FAIL wr_rd_data got %h ok=%0d want 00001234", got, ok); end
   endtask

   task automatic test_write_collision();
      bit ok;
      logic [31:0] got;
      wa[0] = 16'd7; wd[0] = 32'hA; wa[1] = 16'd7; wd[1] = 32'hB; wv = 2'b11;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         step();
         ok = (wr == 2'b11);
      end
      checks++; if (wr !== 2'b11) begin errors++; $display("FAIL collide_ready got %b want 11", wr); end
      wv = 2'b00;
      step();
      checks++; if (wr !== 2'b00) begin errors++; $display("FAIL collide_drop got %b want 00", wr); end
      chan_read(0, 16'd7, got, ok);
      checks++; if (!ok || got !== 32'hB) begin errors++; $display("FAIL collide_winner got %h ok=%0d want 0000000b", got, ok); end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] got;
      chan_write(0, 16'h0405, 32'h55, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_wr_ready got 0 want 1 (timeout)"); end
      chan_read(1, 16'h0005, got, ok);
      checks++; if (!ok || got !== 32'h55) begin errors++; $display("FAIL wrap_data got %h ok=%0d want 00000055", got, ok); end
   endtask

   task automatic test_read_during_write();
      bit ok;
      logic [31:0] got;
      preload(16'd20, 32'h111);
      ra[1] = 16'd20; wa[0] = 16'd20; wd[0] = 32'h222;
      rv[1] = 1'b1; wv[0] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         step();
         ok = rr[1] && wr[0];
      end
      checks++; if (!ok) begin errors++; $display("FAIL rdw_ready got rr=%b wr=%b want both", rr, wr); end
      checks++; if (rd[1] !== 32'h111) begin errors++; $display("FAIL rdw_old_data got %h want 00000111", rd[1]); end
      rv[1] = 1'b0; wv[0] = 1'b0;
      step();
      chan_read(0, 16'd20, got, ok);
      checks++; if (!ok || got !== 32'h222) begin errors++; $display("FAIL rdw_new_data got %h ok=%0d want 00000222", got, ok); end
   endtask

   task automatic test_init_override();
      bit ok;
      logic [31:0] got;
      wa[0] = 16'd30; wd[0] = 32'hC0C0; wv[0] = 1'b1;
      step();
      step();
      init_we = 1'b1; init_address = 16'd30; init_data = 32'hDD;
      step();
      init_we = 1'b0;
      checks++; if (wr[0] !== 1'b1) begin errors++; $display("FAIL init_ovr_ready got %b want 1", wr[0]); end
      wv[0] = 1'b0;
      step();
      chan_read(1, 16'd30, got, ok);
      checks++; if (!ok || got !== 32'hC0C0) begin errors++; $display("FAIL init_ovr_data got %h ok=%0d want 0000c0c0", got, ok); end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      logic [31:0] got;
      preload(16'd9, 32'h1);
      wa[0] = 16'd9; wd[0] = 32'h2; wv[0] = 1'b1;
      step();
      reset = 1'b0;
      for (int n = 0; n < 2; n++) begin
         step();
         checks++;
         if (wr[0] !== 1'b0) begin errors++; $display("FAIL midreset_ready cycle %0d got %b want 0", n, wr[0]); end
      end
      wv[0] = 1'b0; reset = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (wr[0]) ok = 1'b1;
      end
      checks++; if (ok) begin errors++; $display("FAIL midreset_late_ready got 1 want 0"); end
      chan_read(0, 16'd9, got, ok);
      checks++; if (!ok || got !== 32'h1) begin errors++; $display("FAIL midreset_data got %h ok=%0d want 00000001", got, ok); end
   endtask

   initial begin
      reset = 1'b0; rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
      init_we = 1'b0; init_address = '0; init_data = '0;
      test_reset();
      test_preload_read();
      test_write_then_read();
      test_write_collision();
      test_wrap();
      test_read_during_write();
      test_init_override();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
